multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle control unit that drives the ALU's control inputs. It fetches one RV32I

---
 rtl/multicycle_ctrl_fsm_if.sv | 45 ++++
 rtl/multicycle_ctrl_fsm.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-unit bus bundle.
//   Fetch side   : instr_valid, instr (in) / instr_ready (out)
//   ALU side     : branch_result (in) / ALUop, ALUSrc, sftmd, Branch* strobes, imm32 (out)
//   Regfile side : reg_write (out)
//   Data memory  : mem_ready (in) / mem_read, mem_write (out)
//   PC / status  : pc_write, pc_src, illegal, mem_err (out)
// The master modport is the control FSM; the slave modport is its environment.
interface multicycle_ctrl_fsm_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        branch_result;
  logic        mem_ready;
  logic [3:0]  ALUop;
  logic        ALUSrc;
  logic        sftmd;
  logic        Branch;
  logic        nBranch;
  logic        Branch_lt;
  logic        Branch_ge;
  logic        Branch_ltu;
  logic        Branch_geu;
  logic [31:0] imm32;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        pc_write;
  logic        pc_src;
  logic        illegal;
  logic        mem_err;

  modport master (
    input  instr_valid, instr, branch_result, mem_ready,
    output instr_ready, ALUop, ALUSrc, sftmd,
           Branch, nBranch, Branch_lt, Branch_ge, Branch_ltu, Branch_geu,
           imm32, reg_write, mem_read, mem_write, pc_write, pc_src, illegal, mem_err
  );

  modport slave (
    output instr_valid, instr, branch_result, mem_ready,
    input  instr_ready, ALUop, ALUSrc, sftmd,
           Branch, nBranch, Branch_lt, Branch_ge, Branch_ltu, Branch_geu,
           imm32, reg_write, mem_read, mem_write, pc_write, pc_src, illegal, mem_err
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control unit. Accepts one instruction per valid/ready
// handshake, decodes it into ALU controls and imm32, then sequences
// EXEC / MEM / WB and emits register-file, memory and PC strobes.
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   bus      if   control bus (master side), see multicycle_ctrl_fsm_if
//   retired  out  count of completed legal instructions, wraps to 0
//
// state  | meaning
// FETCH  | instr_ready high (one cycle after reset), wait for instr_valid
// DECODE | ALU controls valid; illegal encodings end the instruction here
// EXEC   | branches resolve and retire; others go to MEM or WB
// MEM    | load/store request held until mem_ready or timeout
// WB     | register write strobe, retire
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_fsm_if.master bus,
  output logic [RET_CNT_W-1:0] retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [7:0] TMR_INIT = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        fetch_q;
  logic        accept;
  logic [7:0]  tmr_q;

  logic        dec_legal, dec_ld, dec_st, dec_bra, dec_src, dec_sft;
  logic [3:0]  dec_aluop;
  logic [5:0]  dec_br;
  logic [31:0] dec_imm;

  logic        bad_q, ld_q, st_q, bra_q, src_q, sft_q;
  logic [3:0]  aluop_q;
  logic [5:0]  br_q;
  logic [31:0] imm_q;

  logic        reg_write, mem_read, mem_write, pc_write, pc_src, illegal, mem_err;
  logic        ret_inc;

  // instr_ready is a flop so it stays low while rst_n is asserted and for
  // the first cycle after release.
  assign accept = fetch_q && bus.instr_valid;

  always_comb begin
    dec_legal = 1'b0;
    dec_ld    = 1'b0;
    dec_st    = 1'b0;
    dec_bra   = 1'b0;
    dec_src   = 1'b0;
    dec_sft   = 1'b0;
    dec_aluop = 4'd0;
    dec_br    = 6'd0;
    dec_imm   = 32'd0;
    case (bus.instr[6:0])
      7'b0110011: begin
        case ({bus.instr[31:25], bus.instr[14:12]})
          {7'h00, 3'b000}: begin dec_legal = 1'b1; dec_aluop = 4'd0; end
          {7'h20, 3'b000}: begin dec_legal = 1'b1; dec_aluop = 4'd1; end
          {7'h00, 3'b100}: begin dec_legal = 1'b1; dec_aluop = 4'd2; end
          {7'h00, 3'b110}: begin dec_legal = 1'b1; dec_aluop = 4'd3; end
          {7'h00, 3'b111}: begin dec_legal = 1'b1; dec_aluop = 4'd4; end
          {7'h00, 3'b001}: begin dec_legal = 1'b1; dec_aluop = 4'd5; dec_sft = 1'b1; end
          {7'h00, 3'b101}: begin dec_legal = 1'b1; dec_aluop = 4'd6; dec_sft = 1'b1; end
          {7'h20, 3'b101}: begin dec_legal = 1'b1; dec_aluop = 4'd7; dec_sft = 1'b1; end
          default: ;
        endcase
      end
      7'b0010011: begin
        case (bus.instr[14:12])
          3'b000: begin dec_legal = 1'b1; dec_aluop = 4'd0; end
          3'b100: begin dec_legal = 1'b1; dec_aluop = 4'd1; end
          3'b110: begin dec_legal = 1'b1; dec_aluop = 4'd2; end
          3'b111: begin dec_legal = 1'b1; dec_aluop = 4'd3; end
          3'b001: begin
            if (bus.instr[31:25] == 7'h00) begin
              dec_legal = 1'b1; dec_aluop = 4'd4; dec_sft = 1'b1;
            end
          end
          3'b101: begin
            if (bus.instr[31:25] == 7'h20) begin
              dec_legal = 1'b1; dec_aluop = 4'd5; dec_sft = 1'b1;
            end else if (bus.instr[31:25] == 7'h00) begin
              dec_legal = 1'b1; dec_aluop = 4'd6; dec_sft = 1'b1;
            end
          end
          default: ;
        endcase
        if (dec_legal) begin
          dec_src = 1'b1;
          // shifts carry a zero-extended shamt, the rest a signed 12-bit immediate
          dec_imm = dec_sft ? {27'd0, bus.instr[24:20]}
                            : {{20{bus.instr[31]}}, bus.instr[31:20]};
        end
      end
      7'b0000011: begin
        if (bus.instr[14:12] == 3'b010) begin
          dec_legal = 1'b1; dec_ld = 1'b1; dec_src = 1'b1;
          dec_imm   = {{20{bus.instr[31]}}, bus.instr[31:20]};
        end
      end
      7'b0100011: begin
        if (bus.instr[14:12] == 3'b010) begin
          dec_legal = 1'b1; dec_st = 1'b1; dec_src = 1'b1;
          dec_imm   = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
        end
      end
      7'b1100011: begin
        case (bus.instr[14:12])
          3'b000:  dec_br = 6'b100000;
          3'b001:  dec_br = 6'b010000;
          3'b100:  dec_br = 6'b001000;
          3'b101:  dec_br = 6'b000100;
          3'b110:  dec_br = 6'b000010;
          3'b111:  dec_br = 6'b000001;
          default: dec_br = 6'b000000;
        endcase
        if (dec_br != 6'd0) begin
          dec_legal = 1'b1; dec_bra = 1'b1;
          dec_imm   = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                       bus.instr[30:25], bus.instr[11:8], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    ret_inc   = 1'b0;
    case (state_q)
      FETCH: begin
        if (accept) state_d = DECODE;
      end
      DECODE: begin
        if (bad_q) begin
          illegal  = 1'b1;
          pc_write = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (bra_q) begin
          pc_write = 1'b1;
          pc_src   = bus.branch_result;
          ret_inc  = 1'b1;
          state_d  = FETCH;
        end else if (ld_q || st_q) begin
          state_d  = MEM;
        end else begin
          state_d  = WB;
        end
      end
      MEM: begin
        mem_read  = ld_q;
        mem_write = st_q;
        // a completing access in the final allowed cycle beats the timeout
        if (bus.mem_ready) begin
          if (ld_q) begin
            state_d = WB;
          end else begin
            pc_write = 1'b1;
            ret_inc  = 1'b1;
            state_d  = FETCH;
          end
        end else if (tmr_q == 8'd0) begin
          mem_err  = 1'b1;
          pc_write = 1'b1;
          state_d  = FETCH;
        end
      end
      WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        ret_inc   = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= (state_d == FETCH);
    end
  end

  // Decoded controls are captured at the handshake and cleared on return to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q   <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      bra_q   <= 1'b0;
      src_q   <= 1'b0;
      sft_q   <= 1'b0;
      aluop_q <= 4'd0;
      br_q    <= 6'd0;
      imm_q   <= 32'd0;
    end else if (accept) begin
      bad_q   <= ~dec_legal;
      ld_q    <= dec_ld;
      st_q    <= dec_st;
      bra_q   <= dec_bra;
      src_q   <= dec_src;
      sft_q   <= dec_sft;
      aluop_q <= dec_aluop;
      br_q    <= dec_br;
      imm_q   <= dec_imm;
    end else if (state_d == FETCH) begin
      bad_q   <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      bra_q   <= 1'b0;
      src_q   <= 1'b0;
      sft_q   <= 1'b0;
      aluop_q <= 4'd0;
      br_q    <= 6'd0;
      imm_q   <= 32'd0;
    end
  end

  // MEM timeout: down-counter loaded on the way into MEM, terminal count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= 8'd0;
    end else if (state_q == EXEC) begin
      tmr_q <= TMR_INIT;
    end else if (state_q == MEM && tmr_q != 8'd0) begin
      tmr_q <= tmr_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (ret_inc) begin
      retired <= retired + 1'b1;
    end
  end

  assign bus.instr_ready = fetch_q;
  assign bus.ALUop       = aluop_q;
  assign bus.ALUSrc      = src_q;
  assign bus.sftmd       = sft_q;
  assign bus.Branch      = br_q[5];
  assign bus.nBranch     = br_q[4];
  assign bus.Branch_lt   = br_q[3];
  assign bus.Branch_ge   = br_q[2];
  assign bus.Branch_ltu  = br_q[1];
  assign bus.Branch_geu  = br_q[0];
  assign bus.imm32       = imm_q;
  assign bus.reg_write   = reg_write;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.illegal     = illegal;
  assign bus.mem_err     = mem_err;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
  localparam int MEM_TO = 15;
  localparam int RET_W  = 4;   // narrow counter so wrap-around is exercised

  localparam int K_R = 0, K_I = 1, K_SH = 2, K_LD = 3, K_ST = 4, K_BR = 5;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         chk_f7;
    int         kind;
    logic [3:0] aluop;
    bit         sft;
    logic [5:0] br;
  } pat_t;

  typedef struct {
    bit          legal;
    bit          ld;
    bit          st;
    bit          bra;
    bit          src;
    bit          sft;
    logic [3:0]  aluop;
    logic [5:0]  br;
    logic [31:0] imm;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [RET_W-1:0] retired;
  logic [51:0] obs_v;

  int vectors = 0;
  int miscompares = 0;
  logic [RET_W-1:0] exp_ret;
  pat_t tbl[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TO), .RET_CNT_W(RET_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .retired (retired)
  );

  assign obs_v = {bus.instr_ready, bus.ALUop, bus.ALUSrc, bus.sftmd,
                  bus.Branch, bus.nBranch, bus.Branch_lt, bus.Branch_ge, bus.Branch_ltu, bus.Branch_geu,
                  bus.imm32, bus.reg_write, bus.mem_read, bus.mem_write,
                  bus.pc_write, bus.pc_src, bus.illegal, bus.mem_err};

  task automatic add_p(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input bit chk_f7, input int kind, input logic [3:0] aluop,
                       input bit sft, input logic [5:0] br);
    pat_t p;
    p.op = op; p.f3 = f3; p.f7 = f7; p.chk_f7 = chk_f7;
    p.kind = kind; p.aluop = aluop; p.sft = sft; p.br = br;
    tbl.push_back(p);
  endtask

  // Instruction-set table: first matching row defines the decode.
  task automatic build_table();
    add_p(7'b0110011, 3'b000, 7'h00, 1, K_R, 4'd0, 0, 6'd0);
    add_p(7'b0110011, 3'b000, 7'h20, 1, K_R, 4'd1, 0, 6'd0);
    add_p(7'b0110011, 3'b100, 7'h00, 1, K_R, 4'd2, 0, 6'd0);
    add_p(7'b0110011, 3'b110, 7'h00, 1, K_R, 4'd3, 0, 6'd0);
    add_p(7'b0110011, 3'b111, 7'h00, 1, K_R, 4'd4, 0, 6'd0);
    add_p(7'b0110011, 3'b001, 7'h00, 1, K_R, 4'd5, 1, 6'd0);
    add_p(7'b0110011, 3'b101, 7'h00, 1, K_R, 4'd6, 1, 6'd0);
    add_p(7'b0110011, 3'b101, 7'h20, 1, K_R, 4'd7, 1, 6'd0);
    add_p(7'b0010011, 3'b000, 7'h00, 0, K_I, 4'd0, 0, 6'd0);
    add_p(7'b0010011, 3'b100, 7'h00, 0, K_I, 4'd1, 0, 6'd0);
    add_p(7'b0010011, 3'b110, 7'h00, 0, K_I, 4'd2, 0, 6'd0);
    add_p(7'b0010011, 3'b111, 7'h00, 0, K_I, 4'd3, 0, 6'd0);
    add_p(7'b0010011, 3'b001, 7'h00, 1, K_SH, 4'd4, 1, 6'd0);
    add_p(7'b0010011, 3'b101, 7'h20, 1, K_SH, 4'd5, 1, 6'd0);
    add_p(7'b0010011, 3'b101, 7'h00, 1, K_SH, 4'd6, 1, 6'd0);
    add_p(7'b0000011, 3'b010, 7'h00, 0, K_LD, 4'd0, 0, 6'd0);
    add_p(7'b0100011, 3'b010, 7'h00, 0, K_ST, 4'd0, 0, 6'd0);
    add_p(7'b1100011, 3'b000, 7'h00, 0, K_BR, 4'd0, 0, 6'b100000);
    add_p(7'b1100011, 3'b001, 7'h00, 0, K_BR, 4'd0, 0, 6'b010000);
    add_p(7'b1100011, 3'b100, 7'h00, 0, K_BR, 4'd0, 0, 6'b001000);
    add_p(7'b1100011, 3'b101, 7'h00, 0, K_BR, 4'd0, 0, 6'b000100);
    add_p(7'b1100011, 3'b110, 7'h00, 0, K_BR, 4'd0, 0, 6'b000010);
    add_p(7'b1100011, 3'b111, 7'h00, 0, K_BR, 4'd0, 0, 6'b000001);
  endtask

  function automatic dec_t model(input logic [31:0] i);
    dec_t d;
    d = '{default: '0};
    foreach (tbl[k]) begin
      if (!d.legal && i[6:0] == tbl[k].op && i[14:12] == tbl[k].f3 &&
          (!tbl[k].chk_f7 || i[31:25] == tbl[k].f7)) begin
        d.legal = 1;
        d.aluop = tbl[k].aluop;
        d.sft   = tbl[k].sft;
        d.br    = tbl[k].br;
        d.ld    = (tbl[k].kind == K_LD);
        d.st    = (tbl[k].kind == K_ST);
        d.bra   = (tbl[k].kind == K_BR);
        d.src   = tbl[k].kind inside {K_I, K_SH, K_LD, K_ST};
        case (tbl[k].kind)
          K_I, K_LD: d.imm = {{20{i[31]}}, i[31:20]};
          K_SH:      d.imm = {27'd0, i[24:20]};
          K_ST:      d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
          K_BR:      d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
          default:   d.imm = 32'd0;
        endcase
      end
    end
    return d;
  endfunction

  function automatic logic [51:0] vec(input bit rdy, input dec_t d, input bit rw, input bit mr,
                                      input bit mw, input bit pw, input bit ps, input bit ill,
                                      input bit me);
    return {rdy, d.aluop, d.src, d.sft, d.br, d.imm, rw, mr, mw, pw, ps, ill, me};
  endfunction

  task automatic chk(input string tag, input logic [51:0] e);
    vectors++;
    assert (obs_v === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, e);
    end
  endtask

  task automatic chk_ret(input string tag);
    vectors++;
    assert (retired === exp_ret) else begin
      miscompares++;
      $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, exp_ret);
    end
  endtask

  task automatic idle();
    dec_t z;
    z = '{default: '0};
    @(negedge clk);
    bus.instr_valid   = 1'b0;
    bus.instr         = $urandom;
    bus.mem_ready     = 1'($urandom);
    bus.branch_result = 1'($urandom);
    #1;
    chk("idle", vec(1, z, 0, 0, 0, 0, 0, 0, 0));
    chk_ret("idle");
  endtask

  // wait_n: MEM cycles before mem_ready arrives; negative means never.
  task automatic run(input logic [31:0] ins, input bit br, input int wait_n, input string tag);
    dec_t d, z;
    bit mem, tmo, in_mem, last;
    int n, len;
    z   = '{default: '0};
    d   = model(ins);
    mem = d.ld || d.st;
    tmo = mem && (wait_n < 0 || wait_n > MEM_TO - 1);
    n   = tmo ? MEM_TO - 1 : wait_n;
    if (!d.legal)          len = 1;
    else if (d.bra)        len = 2;
    else if (d.ld && !tmo) len = 4 + n;
    else if (mem)          len = 3 + n;
    else                   len = 3;

    @(negedge clk);
    bus.instr_valid   = 1'b1;
    bus.instr         = ins;
    bus.mem_ready     = 1'($urandom);
    bus.branch_result = 1'($urandom);
    #1;
    chk({tag, "_hs"}, vec(1, z, 0, 0, 0, 0, 0, 0, 0));
    chk_ret({tag, "_hs"});

    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      bus.instr_valid   = 1'($urandom);
      bus.instr         = $urandom;
      bus.branch_result = (c == 2) ? br : 1'($urandom);
      in_mem = mem && c >= 3 && c <= 3 + n;
      if (in_mem) bus.mem_ready = !tmo && (c == 3 + n);
      else        bus.mem_ready = 1'($urandom);
      #1;
      last = (c == len);
      chk($sformatf("%s_c%0d", tag, c),
          vec(0, d,
              last && d.legal && !d.bra && !d.st && !tmo,
              in_mem && d.ld,
              in_mem && d.st,
              last,
              last && d.bra && br,
              !d.legal && c == 1,
              tmo && last));
    end
    if (d.legal && !tmo) exp_ret = exp_ret + 1'b1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    pat_t p;
    r = $urandom;
    if ($urandom_range(0, 4) == 0) return r;
    p = tbl[$urandom_range(0, tbl.size() - 1)];
    r[6:0]   = p.op;
    r[14:12] = p.f3;
    if (p.chk_f7) r[31:25] = p.f7;
    if ($urandom_range(0, 7) == 0) r[25 + $urandom_range(0, 6)] ^= 1'b1;
    return r;
  endfunction

  initial begin
    dec_t d, z;
    int w;
    z = '{default: '0};
    build_table();
    exp_ret           = '0;
    rst_n             = 1'b0;
    bus.instr_valid   = 1'b0;
    bus.instr         = 32'd0;
    bus.mem_ready     = 1'b0;
    bus.branch_result = 1'b0;
    #1;
    chk("reset", vec(0, z, 0, 0, 0, 0, 0, 0, 0));
    chk_ret("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();

    run(32'h002081B3, 0, 0,  "add");
    run(32'h40335293, 0, 0,  "srai");
    run(32'hFE208CE3, 1, 0,  "beq_taken");
    run(32'hFE208CE3, 0, 0,  "beq_not");
    run(32'h0040A103, 0, 3,  "lw_wait3");
    run(32'h0040A103, 0, -1, "lw_timeout");
    run(32'h0040A103, 0, MEM_TO - 1, "lw_ready_at_limit");
    run(32'h0020A223, 0, 0,  "sw");
    run(32'h0020A223, 0, -1, "sw_timeout");
    run(32'h02000033, 0, 0,  "mul_illegal");
    idle();

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) idle();
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) - 1 : $urandom_range(0, 3);
      run(rnd_instr(), 1'($urandom), w, "rnd");
    end

    // reset while a store is waiting in MEM
    d = model(32'h0020A223);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h0020A223;
    bus.mem_ready   = 1'b0;
    #1;
    chk("rst_sw_hs", vec(1, z, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_sw_mem", vec(0, d, 0, 0, 1, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    exp_ret = '0;
    chk("rst_sw_abort", vec(0, z, 0, 0, 0, 0, 0, 0, 0));
    chk_ret("rst_sw_abort");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    run(32'h002081B3, 0, 0, "add_after_rst");
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
